mem_port_arbiter: RTL

Two-requester arbiter that shares one single-port memory between the core's instruction-fetch port and its load/store port, for unified-memory SoC builds. It sits between the pipelined rv32i core and the memory controller. It registers the winning request, holds it on a req/ack memory handshake, and returns a one-cycle valid pulse with registered read data to the requester that was served. When both sides are pending, arbitration is round-robin, so neither port starves.

---
 rtl/mem_port_arbiter.sv | 122 ++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory between the instruction
// fetch port and the load/store port over a req/ack handshake.
module mem_port_arbiter #(
  parameter logic RESET_LAST_GRANT = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ip_inst_req,
  input  logic [31:0] ip_inst_addr,
  output logic        op_inst_valid,
  output logic [31:0] op_inst_data,
  input  logic        ip_data_rd,
  input  logic        ip_data_wr,
  input  logic [31:0] ip_data_addr,
  input  logic [3:0]  ip_data_mask,
  input  logic [31:0] ip_data_wdata,
  output logic        op_data_valid,
  output logic [31:0] op_data_rdata,
  output logic        op_mem_req,
  output logic        op_mem_we,
  output logic [31:0] op_mem_addr,
  output logic [3:0]  op_mem_mask,
  output logic [31:0] op_mem_wdata,
  input  logic        ip_mem_ack,
  input  logic [31:0] ip_mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  state_t state;
  logic   last_grant;   // 0 = instruction, 1 = data

  logic inst_pend;
  logic data_pend;
  logic grant_i;
  logic grant_d;
  logic mem_done;

  // A side whose valid is pulsing has not yet dropped its request; mask it.
  always_comb begin
    inst_pend = ip_inst_req & ~op_inst_valid;
    data_pend = (ip_data_rd | ip_data_wr) & ~op_data_valid;
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    if (state == IDLE) begin
      if (inst_pend && data_pend) begin
        grant_d = ~last_grant;
        grant_i = last_grant;
      end else begin
        grant_i = inst_pend;
        grant_d = data_pend;
      end
    end
  end

  assign mem_done = ip_mem_ack & op_mem_req;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      last_grant    <= RESET_LAST_GRANT;
      op_mem_req    <= 1'b0;
      op_mem_we     <= 1'b0;
      op_mem_addr   <= '0;
      op_mem_mask   <= '0;
      op_mem_wdata  <= '0;
      op_inst_valid <= 1'b0;
      op_data_valid <= 1'b0;
      op_inst_data  <= '0;
      op_data_rdata <= '0;
    end else begin
      op_inst_valid <= 1'b0;
      op_data_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_d) begin
            state        <= BUSY_D;
            last_grant   <= 1'b1;
            op_mem_req   <= 1'b1;
            op_mem_we    <= ip_data_wr;
            op_mem_addr  <= ip_data_addr;
            op_mem_mask  <= ip_data_mask;
            op_mem_wdata <= ip_data_wdata;
          end else if (grant_i) begin
            state        <= BUSY_I;
            last_grant   <= 1'b0;
            op_mem_req   <= 1'b1;
            op_mem_we    <= 1'b0;
            op_mem_addr  <= ip_inst_addr;
            op_mem_mask  <= '1;
            op_mem_wdata <= ip_data_wdata;
          end
        end
        BUSY_I: begin
          if (mem_done) begin
            state         <= IDLE;
            op_mem_req    <= 1'b0;
            op_inst_valid <= 1'b1;
            op_inst_data  <= ip_mem_rdata;
          end
        end
        BUSY_D: begin
          if (mem_done) begin
            state         <= IDLE;
            op_mem_req    <= 1'b0;
            op_data_valid <= 1'b1;
            op_data_rdata <= ip_mem_rdata;
          end
        end
        default: begin
          state      <= IDLE;
          op_mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
